// File: rtl/pull_handshake_deserializer.sv
// Pulls single bits from a FIFO pull port using a four-phase req/ack handshake and assembles
// them into WORD_BITS-wide words. The output word is double-buffered behind a valid/taken pair.
module pull_handshake_deserializer #(
    parameter int WORD_BITS  = 4,
    parameter int COUNT_BITS = 3,
    parameter int GAP_CYCLES = 0,
    parameter int MSB_FIRST  = 0
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 enable,
    output logic                 pullReq,
    input  logic                 pullAck,
    input  logic                 pullValue,
    output logic [WORD_BITS-1:0] word,
    output logic                 wordValid,
    input  logic                 wordTaken,
    output logic                 busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [COUNT_BITS-1:0] FULL_COUNT = COUNT_BITS'(WORD_BITS);
    localparam logic [GAP_W-1:0]      GAP_LOAD   = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_HIGH,
        S_REQ_LOW,
        S_GAP,
        S_DELIVER
    } state_t;

    state_t                state;
    logic [WORD_BITS-1:0]  shift_reg;
    logic [WORD_BITS-1:0]  shift_ins;
    logic [COUNT_BITS-1:0] bit_count;
    logic [GAP_W-1:0]      gap_count;

    state_t decide_state;
    state_t post_state;
    logic   post_req;
    logic   post_busy;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        shift_ins = shift_reg;
        for (int i = 0; i < WORD_BITS; i++) begin
            if (bit_count == COUNT_BITS'(i)) begin
                shift_ins[(MSB_FIRST != 0) ? (WORD_BITS - 1 - i) : i] = pullValue;
            end
        end
    end

    // Where to go once a bit (or a word) is finished: optional gap, else re-raise at once.
    always_comb begin
        decide_state = enable ? S_REQ_HIGH : S_IDLE;
        post_state   = (GAP_CYCLES > 0) ? S_GAP : decide_state;
        post_req     = (GAP_CYCLES == 0) && enable;
        post_busy    = (post_state != S_IDLE);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= S_IDLE;
            pullReq   <= 1'b0;
            word      <= '0;
            wordValid <= 1'b0;
            busy      <= 1'b0;
            shift_reg <= '0;
            bit_count <= '0;
            gap_count <= '0;
        end else begin
            // NOTE: non-blocking; the last assignment in this block wins, so a DELIVER
            // load below overrides this taken-clear and wordValid stays high.
            if (wordTaken && wordValid) begin
                wordValid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        pullReq <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_REQ_HIGH;
                    end
                end

                S_REQ_HIGH: begin
                    if (pullAck) begin
                        shift_reg <= shift_ins;
                        bit_count <= bit_count + COUNT_BITS'(1);
                        pullReq   <= 1'b0;
                        state     <= S_REQ_LOW;
                    end
                end

                S_REQ_LOW: begin
                    if (!pullAck) begin
                        if (bit_count == FULL_COUNT) begin
                            state <= S_DELIVER;
                        end else begin
                            state     <= post_state;
                            pullReq   <= post_req;
                            busy      <= post_busy;
                            gap_count <= GAP_LOAD;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_count <= GAP_W'(1)) begin
                        state   <= decide_state;
                        pullReq <= enable;
                        busy    <= enable;
                    end else begin
                        gap_count <= gap_count - GAP_W'(1);
                    end
                end

                S_DELIVER: begin
                    if (!wordValid || wordTaken) begin
                        word      <= shift_reg;
                        wordValid <= 1'b1;
                        bit_count <= '0;
                        shift_reg <= '0;
                        state     <= post_state;
                        pullReq   <= post_req;
                        busy      <= post_busy;
                        gap_count <= GAP_LOAD;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    pullReq <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pull_handshake_deserializer.sv
// Directed bench: two deserializers (no gap LSB-first, 3-cycle gap MSB-first) each fed by a
// level-ack FIFO model that answers on the falling clock edge.
module tb_pull_handshake_deserializer;

    localparam int WB = 4;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic [1:0]    enable = '0;
    logic [1:0]    pull_req;
    logic [1:0]    pull_ack = '0;
    logic [1:0]    pull_value = '0;
    logic [1:0]    word_valid;
    logic [1:0]    word_taken = '0;
    logic [1:0]    busy;
    logic [WB-1:0] word0;
    logic [WB-1:0] word1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs[2];
    int viol[2];
    int ack_cyc[2];
    bit fifo[2][$];
    int gaps[2][$];

    pull_handshake_deserializer #(
        .WORD_BITS(WB), .COUNT_BITS(3), .GAP_CYCLES(0), .MSB_FIRST(0)
    ) dut0 (
        .clock(clock), .clear(clear), .enable(enable[0]),
        .pullReq(pull_req[0]), .pullAck(pull_ack[0]), .pullValue(pull_value[0]),
        .word(word0), .wordValid(word_valid[0]), .wordTaken(word_taken[0]), .busy(busy[0])
    );

    pull_handshake_deserializer #(
        .WORD_BITS(WB), .COUNT_BITS(3), .GAP_CYCLES(3), .MSB_FIRST(1)
    ) dut1 (
        .clock(clock), .clear(clear), .enable(enable[1]),
        .pullReq(pull_req[1]), .pullAck(pull_ack[1]), .pullValue(pull_value[1]),
        .word(word1), .wordValid(word_valid[1]), .wordTaken(word_taken[1]), .busy(busy[1])
    );

    initial forever #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // FIFO pull-side model: ack rises one half-cycle after req if data exists, falls after req falls.
    initial forever begin
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            if (clear) begin
                pull_ack[d]   = 1'b0;
                pull_value[d] = 1'b0;
                hs[d]         = 0;
            end else if (pull_ack[d]) begin
                if (!pull_req[d]) pull_ack[d] = 1'b0;
            end else if (pull_req[d] && fifo[d].size() > 0) begin
                pull_value[d] = fifo[d].pop_front();
                pull_ack[d]   = 1'b1;
                hs[d]++;
                ack_cyc[d]    = cyc;
            end
        end
    end

    // Edge monitor: counts req rising while ack high, and clocks from ack-low seen to next req rise.
    initial begin
        logic [1:0] prev_req;
        logic [1:0] prev_ack;
        int         done[2];
        prev_req = '0;
        prev_ack = '0;
        done[0]  = -1;
        done[1]  = -1;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            for (int d = 0; d < 2; d++) begin
                if (clear) begin
                    prev_req[d] = 1'b0;
                    prev_ack[d] = 1'b0;
                    done[d]     = -1;
                    viol[d]     = 0;
                    gaps[d].delete();
                end else begin
                    if (pull_req[d] && !prev_req[d] && pull_ack[d]) viol[d]++;
                    if (prev_ack[d] && !pull_ack[d]) done[d] = cyc;
                    if (pull_req[d] && !prev_req[d] && done[d] >= 0) gaps[d].push_back(cyc - done[d]);
                    prev_req[d] = pull_req[d];
                    prev_ack[d] = pull_ack[d];
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        clear      = 1'b1;
        enable     = '0;
        word_taken = '0;
        fifo[0].delete();
        fifo[1].delete();
        step(2);
        clear = 1'b0;
        step(1);
    endtask

    task automatic wait_valid(input int d, input int limit);
        for (int n = 0; n < limit && word_valid[d] !== 1'b1; n++) step(1);
    endtask

    task automatic wait_hs(input int d, input int count, input int limit);
        for (int n = 0; n < limit && hs[d] < count; n++) step(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pull_req[0] !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", pull_req[0]); end
        checks++; if (word_valid[0] !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", word_valid[0]); end
        checks++; if (word0 !== 4'h0) begin failures++; $display("FAIL reset_word: got %h expected 0", word0); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
        enable[0] = 1'b1;
        step(1);
        checks++; if (pull_req[0] !== 1'b1) begin failures++; $display("FAIL req_rise: got %b expected 1", pull_req[0]); end
        #2;
        clear = 1'b1;
        #1;
        checks++; if (pull_req[0] !== 1'b0) begin failures++; $display("FAIL clear_req: got %b expected 0", pull_req[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL clear_busy: got %b expected 0", busy[0]); end
        checks++; if (word_valid[0] !== 1'b0) begin failures++; $display("FAIL clear_valid: got %b expected 0", word_valid[0]); end
    endtask

    task automatic test_basic_word();
        do_reset();
        fifo[0] = '{1, 0, 1, 1};
        enable[0] = 1'b1;
        wait_valid(0, 100);
        checks++; if (word_valid[0] !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", word_valid[0]); end
        checks++; if (word0 !== 4'b1101) begin failures++; $display("FAIL basic_word: got %b expected 1101", word0); end
        checks++; if (hs[0] !== 4) begin failures++; $display("FAIL basic_handshakes: got %0d expected 4", hs[0]); end
        checks++; if (viol[0] !== 0) begin failures++; $display("FAIL basic_req_during_ack: got %0d expected 0", viol[0]); end
        checks++; if ((gaps[0].size() > 0 ? gaps[0][0] : -1) !== 0) begin failures++; $display("FAIL basic_no_gap: got %0d expected 0", gaps[0].size() > 0 ? gaps[0][0] : -1); end
    endtask

    task automatic test_empty_fifo();
        int lat;
        do_reset();
        enable[0] = 1'b1;
        step(52);
        checks++; if (pull_req[0] !== 1'b1) begin failures++; $display("FAIL empty_req_held: got %b expected 1", pull_req[0]); end
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL empty_busy: got %b expected 1", busy[0]); end
        checks++; if (hs[0] !== 0) begin failures++; $display("FAIL empty_no_sample: got %0d expected 0", hs[0]); end
        fifo[0].push_back(1'b1);
        for (int n = 0; n < 10 && (hs[0] == 0 || pull_req[0] !== 1'b0); n++) step(1);
        lat = cyc - ack_cyc[0];
        checks++; if ((hs[0] == 1 && lat >= 1 && lat <= 3) !== 1'b1) begin failures++; $display("FAIL empty_capture_latency: got hs=%0d clocks=%0d expected hs=1 clocks 1..3", hs[0], lat); end
        fifo[0] = '{0, 0, 1};
        wait_valid(0, 100);
        checks++; if (word0 !== 4'b1001) begin failures++; $display("FAIL empty_word: got %b expected 1001", word0); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        fifo[0] = '{0, 1, 0, 1, 0, 0, 1, 1};
        enable[0] = 1'b1;
        wait_valid(0, 100);
        checks++; if (word0 !== 4'b1010) begin failures++; $display("FAIL bp_first_word: got %b expected 1010", word0); end
        wait_hs(0, 8, 100);
        step(4);
        checks++; if (word_valid[0] !== 1'b1) begin failures++; $display("FAIL bp_held_valid: got %b expected 1", word_valid[0]); end
        checks++; if (word0 !== 4'b1010) begin failures++; $display("FAIL bp_held_word: got %b expected 1010", word0); end
        checks++; if (pull_req[0] !== 1'b0) begin failures++; $display("FAIL bp_stall_req: got %b expected 0", pull_req[0]); end
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL bp_stall_busy: got %b expected 1", busy[0]); end
        checks++; if (hs[0] !== 8) begin failures++; $display("FAIL bp_handshakes: got %0d expected 8", hs[0]); end
        word_taken[0] = 1'b1;
        step(1);
        word_taken[0] = 1'b0;
        checks++; if (word0 !== 4'b1100) begin failures++; $display("FAIL bp_second_word: got %b expected 1100", word0); end
        checks++; if (word_valid[0] !== 1'b1) begin failures++; $display("FAIL bp_valid_kept: got %b expected 1", word_valid[0]); end
        checks++; if (pull_req[0] !== 1'b1) begin failures++; $display("FAIL bp_rerequest: got %b expected 1", pull_req[0]); end
        word_taken[0] = 1'b1;
        step(1);
        word_taken[0] = 1'b0;
        checks++; if (word_valid[0] !== 1'b0) begin failures++; $display("FAIL take_clears_valid: got %b expected 0", word_valid[0]); end
        checks++; if (word0 !== 4'b1100) begin failures++; $display("FAIL take_keeps_word: got %b expected 1100", word0); end
        word_taken[0] = 1'b1;
        step(1);
        word_taken[0] = 1'b0;
        checks++; if (word_valid[0] !== 1'b0) begin failures++; $display("FAIL take_when_empty: got %b expected 0", word_valid[0]); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        fifo[0] = '{1, 1, 0, 1};
        enable[0] = 1'b1;
        wait_hs(0, 2, 100);
        enable[0] = 1'b0;
        step(10);
        checks++; if (pull_req[0] !== 1'b0) begin failures++; $display("FAIL park_req: got %b expected 0", pull_req[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL park_busy: got %b expected 0", busy[0]); end
        checks++; if (hs[0] !== 2) begin failures++; $display("FAIL park_handshakes: got %0d expected 2", hs[0]); end
        checks++; if (word_valid[0] !== 1'b0) begin failures++; $display("FAIL park_valid: got %b expected 0", word_valid[0]); end
        enable[0] = 1'b1;
        wait_valid(0, 100);
        checks++; if (word0 !== 4'b1011) begin failures++; $display("FAIL resume_word: got %b expected 1011", word0); end
        checks++; if (hs[0] !== 4) begin failures++; $display("FAIL resume_handshakes: got %0d expected 4", hs[0]); end
    endtask

    task automatic test_gap_msb_first();
        do_reset();
        fifo[1] = '{1, 0, 1, 1};
        enable[1] = 1'b1;
        wait_valid(1, 200);
        checks++; if (word1 !== 4'b1011) begin failures++; $display("FAIL gap_msb_word: got %b expected 1011", word1); end
        checks++; if (hs[1] !== 4) begin failures++; $display("FAIL gap_handshakes: got %0d expected 4", hs[1]); end
        checks++; if (gaps[1].size() < 3) begin failures++; $display("FAIL gap_count: got %0d expected >=3", gaps[1].size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ((gaps[1].size() > k ? gaps[1][k] : -1) !== 3) begin
                failures++;
                $display("FAIL gap_clocks[%0d]: got %0d expected 3", k, gaps[1].size() > k ? gaps[1][k] : -1);
            end
        end
        checks++; if (viol[1] !== 0) begin failures++; $display("FAIL gap_req_during_ack: got %0d expected 0", viol[1]); end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_empty_fifo();
        test_back_pressure();
        test_enable_drop();
        test_gap_msb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
